// File: rtl/flex_fifo_pkg.sv
// Shared constants and elaboration helpers for the flex_fifo block.
package flex_fifo_pkg;

   // Read-port modes: FWFT shows the head word combinationally, STD registers it on a read.
   localparam int FWFT_MODE = 1;
   localparam int STD_MODE  = 0;

   // Ceiling log2; the number of address bits needed to index 'depth' entries.
   function automatic int addr_width(input int depth);
      int w;
      w = 0;
      while (((1 << w) < depth) && (w < 30)) begin
         w = w + 1;
      end
      return w;
   endfunction

   // True for powers of two that are at least 2.
   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage for flex_fifo: synchronous write port, asynchronous read port.
// The array carries no reset so it can map onto distributed/LUT RAM.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Write port: store the word on the clock edge when enabled.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flex_fifo.sv
// Synchronous FIFO with wrap-bit pointers, programmable almost flags,
// overflow/underflow pulses and a selectable FWFT or registered read port.
module flex_fifo
   import flex_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = FWFT_MODE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic [DATA_WIDTH-1:0]       din,
   input  logic                        wren,
   input  logic                        rden,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [addr_width(DEPTH):0]  count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int AW = addr_width(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("flex_fifo: DEPTH must be a power of two and at least 2");
   end
   if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
      $error("flex_fifo: AE_LEVEL must be below AF_LEVEL");
   end

   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic                  overflow_q, underflow_q;
   logic                  rd_ok, wr_ok, ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Status is decoded from the registered pointers only, so flags never glitch on inputs.
   assign empty        = (wptr_q == rptr_q);
   assign full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign count        = wptr_q - rptr_q;
   assign almost_full  = (count >= AF_THR);
   assign almost_empty = (count <= AE_THR);

   // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
   assign rd_ok  = rden && !empty;
   assign wr_ok  = wren && (!full || rd_ok);
   assign ram_we = wr_ok && !clr;

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Next-state pointers: flush wins, otherwise each accepted request advances its pointer.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clr) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_ok) wptr_d = wptr_q + PW'(1);
         if (rd_ok) rptr_d = rptr_q + PW'(1);
      end
   end

   // Pointer and error-pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= !clr && wren && !wr_ok;
         underflow_q <= !clr && rden && empty;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (din),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   if (FWFT != STD_MODE) begin : g_fwft
      // Head word falls through; forced to zero while nothing is stored.
      assign dout = empty ? '0 : ram_rdata;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      // Registered read: capture the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= '0;
         end else if (clr) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= ram_rdata;
         end
      end

      assign dout = dout_q;
   end

endmodule

// File: tb/tb_flex_fifo.sv
// Randomised and directed bench for flex_fifo; one FWFT and one registered-read
// instance receive identical stimulus and are compared against a queue model.
module tb_flex_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic [DW-1:0] din = '0;
   logic          wren = 1'b0;
   logic          rden = 1'b0;

   logic [DW-1:0] f_dout, s_dout;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic [4:0]    f_count, s_count;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   // Reference model: queue contents plus the registered-read output and error pulses.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dstd = '0;
   bit            m_ovf  = 1'b0;
   bit            m_unf  = 1'b0;

   always #5 clk = ~clk;

   flex_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .wren(wren), .rden(rden),
      .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   flex_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .wren(wren), .rden(rden),
      .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn, got, exp);
      end
   endtask

   // Compare both instances against the model's current view of the FIFO.
   task automatic check_outputs();
      int            n;
      logic [DW-1:0] head;
      n    = mq.size();
      head = (n > 0) ? mq[0] : '0;
      check_val("fwft.count", 32'(f_count), 32'(n));
      check_val("fwft.empty", 32'(f_empty), 32'(n == 0));
      check_val("fwft.full",  32'(f_full),  32'(n == DEPTH));
      check_val("fwft.afull", 32'(f_af),    32'(n >= AF));
      check_val("fwft.aempty",32'(f_ae),    32'(n <= AE));
      check_val("fwft.ovf",   32'(f_ovf),   32'(m_ovf));
      check_val("fwft.unf",   32'(f_unf),   32'(m_unf));
      check_val("fwft.dout",  32'(f_dout),  32'(head));
      check_val("std.count",  32'(s_count), 32'(n));
      check_val("std.empty",  32'(s_empty), 32'(n == 0));
      check_val("std.full",   32'(s_full),  32'(n == DEPTH));
      check_val("std.afull",  32'(s_af),    32'(n >= AF));
      check_val("std.aempty", 32'(s_ae),    32'(n <= AE));
      check_val("std.ovf",    32'(s_ovf),   32'(m_ovf));
      check_val("std.unf",    32'(s_unf),   32'(m_unf));
      check_val("std.dout",   32'(s_dout),  32'(m_dstd));
   endtask

   // One clock of stimulus: apply inputs, advance the model, then check after the edge.
   task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
      bit was_empty, was_full, rd_ok, wr_ok;
      wren = w; rden = r; clr = c; din = d;
      if (c) begin
         mq.delete();
         m_dstd = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         was_empty = (mq.size() == 0);
         was_full  = (mq.size() == DEPTH);
         rd_ok     = r && !was_empty;
         wr_ok     = w && (!was_full || rd_ok);
         m_ovf     = w && !wr_ok;
         m_unf     = r && was_empty;
         if (rd_ok) m_dstd = mq.pop_front();
         if (wr_ok) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d wr=%b rd=%b clr=%b din=%02h count=%0d", txn, w, r, c, d, mq.size());
      check_outputs();
   endtask

   // Asynchronous reset pulse between clock edges; outputs must settle before the next edge.
   task automatic async_reset();
      wren = 1'b0; rden = 1'b0; clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      mq.delete();
      m_dstd = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      txn++;
      $display("txn %0d async reset asserted", txn);
      check_outputs();
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d reset released", txn);
      check_outputs();
   endtask

   initial begin
      logic [DW-1:0] d;
      int            wbias, rbias;

      repeat (3) @(posedge clk);
      #1;
      txn++;
      $display("txn %0d reset held", txn);
      check_outputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fill 0x00..0x0F, then a rejected 17th write.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
      step(1'b1, 1'b0, 1'b0, 8'hEE);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Drain in order, then read at empty.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Simultaneous write and read on an empty FIFO: only the write lands.
      step(1'b1, 1'b1, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      // Refill, then 40 cycles of concurrent write+read while full across pointer wrap.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h80 + i));
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

      // Registered read latency and hold.
      step(1'b1, 1'b0, 1'b0, 8'hA5);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Flush at count 7 with a concurrent write that must be dropped.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
      step(1'b1, 1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Asynchronous reset in the middle of a burst at count 9.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
      async_reset();
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Random traffic with alternating write-heavy and read-heavy phases.
      for (int p = 0; p < 6; p++) begin
         wbias = (p % 2 == 0) ? 75 : 30;
         rbias = (p % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 120; i++) begin
            d = DW'($urandom);
            step($urandom_range(0, 99) < wbias,
                 $urandom_range(0, 99) < rbias,
                 $urandom_range(0, 63) == 0,
                 d);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
